// File: rtl/rr_src_mux.sv
// Registered N-way source selector: one requester is granted per cycle, its data
// is captured into a single output register and held until the consumer accepts.
module rr_src_mux #(
   parameter int WIDTH = 16,
   parameter int N     = 4,
   parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req_i,
   input  logic [N*WIDTH-1:0]   data_in_i,
   input  logic                 mode_i,
   input  logic                 lock_i,
   output logic [N-1:0]         gnt_o,
   output logic [WIDTH-1:0]     out_data_o,
   output logic [SELW-1:0]      out_sel_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i
);

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SELW-1:0]  out_sel_q,  out_sel_d;
   logic             out_valid_q, out_valid_d;
   logic [SELW-1:0]  ptr_q, ptr_d;
   logic [SELW-1:0]  last_q, last_d;
   logic             last_vld_q, last_vld_d;

   logic             can_accept;
   logic             win_vld;
   logic [SELW-1:0]  win;
   logic [N-1:0]     gnt;

   assign can_accept = !out_valid_q || out_ready_i;

   // Winner search: loops run from the far end so the first match in scan order
   // is the one left standing.
   always_comb begin
      win_vld = 1'b0;
      win     = '0;
      gnt     = '0;
      if (rst_n && can_accept && (|req_i)) begin
         win_vld = 1'b1;
         if (lock_i && last_vld_q && req_i[last_q]) begin
            win = last_q;
         end else if (!mode_i) begin
            for (int i = N - 1; i >= 0; i--) begin
               if (req_i[i]) win = SELW'(i);
            end
         end else begin
            for (int k = N - 1; k >= 0; k--) begin
               if (req_i[(int'(ptr_q) + k) % N]) win = SELW'((int'(ptr_q) + k) % N);
            end
         end
         gnt[win] = 1'b1;
      end
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      last_d      = last_q;
      last_vld_d  = last_vld_q;
      if (win_vld) begin
         out_data_d  = data_in_i[int'(win)*WIDTH +: WIDTH];
         out_sel_d   = win;
         out_valid_d = 1'b1;
         last_d      = win;
         last_vld_d  = 1'b1;
         if (mode_i) begin
            ptr_d = (win == SELW'(N - 1)) ? '0 : win + SELW'(1);
         end
      end else if (out_valid_q && out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_sel_q   <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
         last_q      <= '0;
         last_vld_q  <= 1'b0;
      end else begin
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
         last_q      <= last_d;
         last_vld_q  <= last_vld_d;
      end
   end

   assign gnt_o       = gnt;
   assign out_data_o  = out_data_q;
   assign out_sel_o   = out_sel_q;
   assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_rr_src_mux.sv
// Bench for rr_src_mux: directed scenarios plus random traffic, all checked
// against a cycle-level reference model of the arbitration rules.
module tb_rr_src_mux;
   localparam int WIDTH = 16;
   localparam int N     = 4;
   localparam int SELW  = 2;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [N-1:0]        req_i;
   logic [N*WIDTH-1:0]  data_in_i;
   logic                mode_i, lock_i, out_ready_i;
   logic [N-1:0]        gnt_o;
   logic [WIDTH-1:0]    out_data_o;
   logic [SELW-1:0]     out_sel_o;
   logic                out_valid_o;

   rr_src_mux #(.WIDTH(WIDTH), .N(N)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req_i), .data_in_i(data_in_i),
      .mode_i(mode_i), .lock_i(lock_i), .gnt_o(gnt_o), .out_data_o(out_data_o),
      .out_sel_o(out_sel_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   bit m_init = 0;
   int m_ptr, m_last, m_data, m_sel;
   bit m_lvld, m_valid;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input bit md, input bit lk);
      if (lk && m_lvld && r[m_last]) return m_last;
      for (int k = 0; k < N; k++) begin
         int i;
         i = md ? (m_ptr + k) % N : k;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   function automatic void set_fixed_data();
      data_in_i = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
   endfunction

   // Called just after a falling edge. Applies inputs, checks outputs and gnt
   // against the model, then advances through one rising edge.
   task automatic step(input bit rn, input logic [N-1:0] r, input bit md,
                       input bit lk, input bit rdy);
      int w;
      rst_n = rn; req_i = r; mode_i = md; lock_i = lk; out_ready_i = rdy;
      #1;
      w = -1;
      if (rn && m_init && (!m_valid || rdy)) w = pick(r, md, lk);
      if (m_init || !rn) chk("gnt", gnt_o, (w >= 0) ? (32'd1 << w) : 32'd0);
      if (m_init) begin
         chk("out_valid", out_valid_o, m_valid);
         chk("out_data", out_data_o, m_data);
         chk("out_sel", out_sel_o, m_sel);
      end
      @(posedge clk);
      if (!rn) begin
         m_init = 1; m_ptr = 0; m_last = 0; m_lvld = 0;
         m_valid = 0; m_data = 0; m_sel = 0;
      end else if (w >= 0) begin
         m_data  = int'(data_in_i[w*WIDTH +: WIDTH]);
         m_sel   = w; m_valid = 1; m_last = w; m_lvld = 1;
         if (md) m_ptr = (w + 1) % N;
      end else if (m_valid && rdy) begin
         m_valid = 0;
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; req_i = '0; mode_i = 1'b0; lock_i = 1'b0; out_ready_i = 1'b1;
      set_fixed_data();
      @(negedge clk);

      // reset and idle
      step(0, 4'b1111, 0, 0, 1);
      step(0, 4'b1111, 0, 0, 1);
      step(1, 4'b0000, 0, 0, 1);
      chk("rst_valid", out_valid_o, 0);
      chk("rst_data", out_data_o, 0);

      // fixed priority
      for (int c = 0; c < 3; c++) begin
         step(1, 4'b1010, 0, 0, 1);
         chk("fp_data", out_data_o, 16'h2222);
         chk("fp_sel", out_sel_o, 1);
      end

      // round-robin rotation with wrap
      step(0, 4'b0000, 1, 0, 1);
      for (int c = 0; c < 6; c++) begin
         step(1, 4'b1111, 1, 0, 1);
         chk("rr_sel", out_sel_o, c % 4);
      end

      // backpressure
      step(0, 4'b0000, 1, 0, 1);
      step(1, 4'b0100, 1, 0, 1);
      chk("bp_cap", out_data_o, 16'h3333);
      for (int c = 0; c < 3; c++) step(1, 4'b1111, 1, 0, 0);
      chk("bp_hold", out_data_o, 16'h3333);
      out_ready_i = 1'b1; req_i = 4'b1111; #1;
      chk("bp_gnt", gnt_o, 4'b1000);
      step(1, 4'b1111, 1, 0, 1);
      chk("bp_next", out_data_o, 16'h4444);
      chk("bp_nobubble", out_valid_o, 1);

      // lock
      step(0, 4'b0000, 1, 1, 1);
      for (int c = 0; c < 3; c++) begin
         step(1, 4'b0101, 1, 1, 1);
         chk("lock_sel", out_sel_o, 0);
      end
      step(1, 4'b0100, 1, 1, 1);
      chk("lock_rel", out_sel_o, 2);

      // reset mid-operation
      step(1, 4'b0010, 1, 0, 0);
      step(0, 4'b1111, 1, 0, 0);
      chk("mid_valid", out_valid_o, 0);
      step(1, 4'b1111, 1, 0, 1);
      chk("mid_sel", out_sel_o, 0);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) data_in_i[i*WIDTH +: WIDTH] = WIDTH'($urandom);
         step(($urandom_range(0, 99) != 0), N'($urandom), (c / 200) % 2 == 1 ? 1'b1 : 1'($urandom_range(0, 9) == 0),
              1'($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/rr_src_mux.md
# rr_src_mux

Parametrised, registered N-way source selector with round-robin or fixed-priority arbitration and valid/ready handshaking on every port. It generalises the datapath's fixed 4:1 16-bit select into a sequential arbiter-mux. It sits where several requesters share one consumer, such as the memory port or the writeback bus. Each requester presents data with a request; the block grants one per cycle, registers the winner's data, and holds it until the consumer accepts.

## Interface
- WIDTH, 16: data width per channel.
- N, 4: channel count, 2..16.
- SELW, $clog2(N): width of channel index.

- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req  in  N  per-channel request (valid); req[i] qualifies data_in slice i.
- data_in  in  N*WIDTH  channel i data at [i*WIDTH +: WIDTH].
- mode  in  1  0 = fixed priority (lowest index wins), 1 = round robin.
- lock  in  1  1 = keep granting the last-granted channel while it still requests.
- gnt  out  N  one-hot accept strobe, combinational; gnt[i]=1 means slice i is captured this edge.
- out_data  out  WIDTH  registered selected data.
- out_sel  out  SELW  index of the channel that produced out_data.
- out_valid  out  1  output register holds unconsumed data.
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready.

## Operation
- State: output register (out_data, out_sel, out_valid), round-robin pointer ptr[SELW-1:0], last-grant index last[SELW-1:0], last_vld.
- Two states, EMPTY (out_valid=0) and FULL (out_valid=1).
- can_accept = !out_valid | out_ready. This gives same-cycle pass-through when the consumer drains.
- Arbitration happens only when can_accept & |req. Otherwise gnt=0.
- Winner selection, in priority order:
  - lock=1 & last_vld & req[last]: winner = last.
  - mode=0: lowest index i with req[i].
  - mode=1: first i with req[i], scanning ptr, ptr+1, ... wrapping mod N.
- On a grant to w:
  - gnt = one-hot(w).
  - Next edge: out_data=data_in[w], out_sel=w, out_valid=1, last=w, last_vld=1.
  - If mode=1: ptr = (w+1) mod N, with wrap from N-1 to 0.
  - If mode=0: ptr unchanged.
  - A lock-forced grant also updates ptr when mode=1.
- Consumer accept (out_valid & out_ready) with no new grant: out_valid→0. out_data and out_sel hold their last values.
- Stall (out_valid & !out_ready): out_data, out_sel, ptr and last are frozen; gnt=0 regardless of req.
- Mode and lock changes take effect on the next arbitration; there is no flush.
- req deasserting while not granted: nothing is lost, since data is only captured on gnt.
- Non-power-of-two N: ptr never holds a value ≥ N.

## Timing
- Reset (rst_n=0 at an edge): out_valid=0, out_data=0, out_sel=0, ptr=0, last=0, last_vld=0.
- During rst_n=0, gnt=0 combinationally. Reset mid-transfer discards held data.
- Latency: 1 cycle from gnt[i]=1 to out_valid=1 carrying data_in[i].
- Throughput: 1 transfer/cycle when out_ready stays 1.
- gnt depends combinationally on req, mode, lock and out_ready. There is no combinational path from data_in to any output.
- Simultaneous consumer accept and new grant in the same cycle: out_valid stays 1 and the register takes the new data. No bubble.
- Simultaneous requests from all N channels with mode=1 and out_ready=1: grants rotate 0,1,…,N-1,0, one per cycle.

## Test plan
- Reset and idle:
  - Stimulus: hold rst_n=0 for 2 cycles with req=4'b1111, then release with req=0.
  - Required: gnt=0 throughout reset; out_valid=0, out_data=0, out_sel=0 after reset.
- Fixed priority:
  - Stimulus: mode=0, req=4'b1010, data_in slices 0x1111/0x2222/0x3333/0x4444 (ch0..3), out_ready=1, 3 cycles.
  - Required: gnt=4'b0010 every cycle; out_data=0x2222 and out_sel=1 from cycle 2.
- Round-robin rotation and wrap:
  - Stimulus: mode=1, req=4'b1111, out_ready=1, 6 cycles.
  - Required: out_sel sequence 0,1,2,3,0,1; ptr wraps from 3 to 0.
- Backpressure:
  - Stimulus: grant ch2 (0x3333), then out_ready=0 for 3 cycles with req=4'b1111.
  - Required: gnt=0 during the stall; out_data=0x3333 and out_valid=1 held.
  - Then out_ready=1: the same-cycle grant goes to ch3 (ptr=3), and out_data=0x4444 appears next cycle with no bubble.
- Lock:
  - Stimulus: mode=1, lock=1, req=4'b0101 for 3 grants, then req[0] drops.
  - Required: ch0 is granted 3 times in a row; the next grant is ch2.
- Reset mid-operation:
  - Stimulus: out_valid=1 with out_ready=0, then pulse rst_n=0 for one cycle.
  - Required: out_valid=0, ptr=0 and last_vld=0 on the following cycle; the next arbitration with mode=1 and req=4'b1111 grants ch0.
